flag_stack_register: RTL



---
 rtl/flagreg_pkg.sv | 25 ++
 rtl/flag_lifo.sv | 82 ++++++++
 rtl/flag_stack_register.sv | 124 ++++++++++++
 3 files changed

// File: rtl/flagreg_pkg.sv
// Shared definitions for the flag stack register: flag bit positions,
// default geometry and a default-width flag vector type.
package flagreg_pkg;

    // Bit positions of the ALU status flags at the default width
    localparam int FLAG_Z = 0;
    localparam int FLAG_V = 1;
    localparam int FLAG_C = 2;
    localparam int FLAG_N = 3;

    // Default geometry
    localparam int DEFAULT_NUM_FLAGS   = 4;
    localparam int DEFAULT_STACK_DEPTH = 4;

    // Flag vector at the default width
    typedef logic [DEFAULT_NUM_FLAGS-1:0] flags_t;

    // Apply a per-bit masked update: masked bits take new_v, others keep old_v
    function automatic flags_t merge_default(input flags_t old_v,
                                             input flags_t new_v,
                                             input flags_t mask_v);
        return (old_v & ~mask_v) | (new_v & mask_v);
    endfunction

endpackage : flagreg_pkg

// File: rtl/flag_lifo.sv
// flag_lifo: LIFO storage for saved flag contexts.
// Holds the storage array and the occupancy counter, and decides which
// push/pop requests are legal. Illegal requests (push when full, pop when
// empty, push and pop together) leave the stack untouched and are reported
// on o_err for the owner to latch. The array itself is never reset; only
// the occupancy counter is, so stale entries are unreachable after reset.
module flag_lifo #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4,
    parameter int SPW   = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_wdata,
    output logic [WIDTH-1:0] o_rdata,
    output logic [SPW-1:0]   o_sp,
    output logic             o_full,
    output logic             o_empty,
    output logic             o_push_ok,
    output logic             o_pop_ok,
    output logic             o_err
);

    // Address width of the storage array; at least one bit so DEPTH=1 works
    localparam int AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int ENTRIES = 1 << AW;

    logic [WIDTH-1:0] r_mem [ENTRIES];
    logic [SPW-1:0]   r_sp;

    logic             w_full;
    logic             w_empty;
    logic             w_push_ok;
    logic             w_pop_ok;
    logic             w_err;
    logic [SPW-1:0]   w_sp_m1;
    logic [AW-1:0]    w_wr_idx;
    logic [AW-1:0]    w_rd_idx;

    // Occupancy decodes, guard logic and array addressing
    always_comb begin
        w_full    = (r_sp == SPW'(DEPTH));
        w_empty   = (r_sp == {SPW{1'b0}});
        w_push_ok = i_push & ~i_pop & ~w_full;
        w_pop_ok  = i_pop & ~i_push & ~w_empty;
        w_err     = (i_push & i_pop) | (i_push & w_full) | (i_pop & w_empty);
        w_sp_m1   = r_sp - SPW'(1);
        w_wr_idx  = r_sp[AW-1:0];
        w_rd_idx  = w_sp_m1[AW-1:0];
    end

    // Occupancy counter: bounded to 0..DEPTH by the push/pop guards
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sp <= {SPW{1'b0}};
        end else if (w_push_ok) begin
            r_sp <= r_sp + SPW'(1);
        end else if (w_pop_ok) begin
            r_sp <= w_sp_m1;
        end else begin
            r_sp <= r_sp;
        end
    end

    // Storage array: written only on a legal push, contents survive reset
    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[w_wr_idx] <= i_wdata;
        end
    end

    assign o_rdata   = r_mem[w_rd_idx];
    assign o_sp      = r_sp;
    assign o_full    = w_full;
    assign o_empty   = w_empty;
    assign o_push_ok = w_push_ok;
    assign o_pop_ok  = w_pop_ok;
    assign o_err     = w_err;

endmodule : flag_lifo

// File: rtl/flag_stack_register.sv
// flag_stack_register: CPU status flag register with per-flag masked writes
// and a LIFO save/restore stack for interrupt/call context.
// Priority for the next flag value: reset, then a legal pop (restore),
// then a masked write, then hold. A push always saves the value held
// before the edge, so push and write on the same edge both take effect.
// Optional build macro FLAGREG_BYPASS_EN adds the combinational output
// flags_next, the value stored_flags will take at the next rising edge.
module flag_stack_register
    import flagreg_pkg::*;
#(
    parameter int NUM_FLAGS   = DEFAULT_NUM_FLAGS,
    parameter int STACK_DEPTH = DEFAULT_STACK_DEPTH,
    parameter int SPW         = $clog2(STACK_DEPTH + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 write,
    input  logic [NUM_FLAGS-1:0] write_mask,
    input  logic [NUM_FLAGS-1:0] flags_alu,
    input  logic                 push,
    input  logic                 pop,
    input  logic                 err_clr,
    output logic [NUM_FLAGS-1:0] stored_flags,
    output logic [SPW-1:0]       sp,
    output logic                 empty,
    output logic                 full,
`ifdef FLAGREG_BYPASS_EN
    output logic [NUM_FLAGS-1:0] flags_next,
`endif
    output logic                 stack_err
);

    logic [NUM_FLAGS-1:0] r_flags;
    logic                 r_err;

    logic [NUM_FLAGS-1:0] w_flags_next;
    logic [NUM_FLAGS-1:0] w_merged;
    logic [NUM_FLAGS-1:0] w_lifo_rdata;
    logic                 w_push_ok;
    logic                 w_pop_ok;
    logic                 w_lifo_err;
    logic                 w_err_next;

    // Width-generic masked merge of new ALU flags into the held flags
    function automatic logic [NUM_FLAGS-1:0] masked_merge(
        input logic [NUM_FLAGS-1:0] old_v,
        input logic [NUM_FLAGS-1:0] new_v,
        input logic [NUM_FLAGS-1:0] mask_v
    );
        return (old_v & ~mask_v) | (new_v & mask_v);
    endfunction

    flag_lifo #(
        .WIDTH (NUM_FLAGS),
        .DEPTH (STACK_DEPTH),
        .SPW   (SPW)
    ) u_lifo (
        .clk       (clk),
        .rst       (rst),
        .i_push    (push),
        .i_pop     (pop),
        .i_wdata   (r_flags),
        .o_rdata   (w_lifo_rdata),
        .o_sp      (sp),
        .o_full    (full),
        .o_empty   (empty),
        .o_push_ok (w_push_ok),
        .o_pop_ok  (w_pop_ok),
        .o_err     (w_lifo_err)
    );

    // Next flag value: reset, then restore from stack, then masked write, then hold
    always_comb begin
        w_merged     = masked_merge(r_flags, flags_alu, write_mask);
        w_flags_next = r_flags;
        if (rst) begin
            w_flags_next = {NUM_FLAGS{1'b0}};
        end else if (w_pop_ok) begin
            w_flags_next = w_lifo_rdata;
        end else if (write) begin
            w_flags_next = w_merged;
        end else begin
            w_flags_next = r_flags;
        end
    end

    // Sticky stack error: a new error on the same edge beats err_clr
    always_comb begin
        w_err_next = r_err;
        if (w_lifo_err) begin
            w_err_next = 1'b1;
        end else if (err_clr) begin
            w_err_next = 1'b0;
        end else begin
            w_err_next = r_err;
        end
    end

    // Architectural flag register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_flags <= {NUM_FLAGS{1'b0}};
        end else begin
            r_flags <= w_flags_next;
        end
    end

    // Stack error register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_err <= 1'b0;
        end else begin
            r_err <= w_err_next;
        end
    end

    assign stored_flags = r_flags;
    assign stack_err    = r_err;

`ifdef FLAGREG_BYPASS_EN
    assign flags_next = w_flags_next;
`endif

endmodule : flag_stack_register
